// File: rtl/rng.sv
// Pseudo-random word generator: 43-bit LFSR, optionally XORed with a 37-bit
// rule 90/150 CASR when the RNG_CASR_EN macro is defined (default: LFSR only).
module rng (
    input  logic        clk,
    input  logic        reset,
    input  logic        loadseed_i,
    input  logic [31:0] seed_i,
    output logic [31:0] number_o,
    input  logic        enable
);

    localparam logic [42:0] LfsrRst = 43'h1;

    logic        seed_zero;
    logic        lfsr_fb;
    logic [42:0] lfsr_q;
    logic [42:0] lfsr_d;
    logic [42:0] lfsr_step;

    assign seed_zero = (seed_i == 32'd0);

    assign lfsr_fb   = lfsr_q[42] ^ lfsr_q[41] ^ lfsr_q[20] ^ lfsr_q[1];
    assign lfsr_step = {lfsr_q[41:0], lfsr_fb};

    // A zero seed would lock the LFSR at zero, so it falls back to reset state.
    always_comb begin
        lfsr_d = lfsr_q;
        if (loadseed_i) begin
            lfsr_d = seed_zero ? LfsrRst : {11'd0, seed_i};
        end else if (enable) begin
            lfsr_d = lfsr_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LfsrRst;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

`ifdef RNG_CASR_EN

    localparam logic [36:0] CasrRst = 37'h2;

    logic [36:0] casr_q;
    logic [36:0] casr_d;
    logic [36:0] casr_step;

    // Rule 90 with null boundaries; cell 27 runs rule 150.
    always_comb begin
        casr_step     = {casr_q[35:0], 1'b0} ^ {1'b0, casr_q[36:1]};
        casr_step[27] = casr_step[27] ^ casr_q[27];
    end

    always_comb begin
        casr_d = casr_q;
        if (loadseed_i) begin
            casr_d = seed_zero ? CasrRst : {5'd0, seed_i};
        end else if (enable) begin
            casr_d = casr_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            casr_q <= CasrRst;
        end else begin
            casr_q <= casr_d;
        end
    end

    assign number_o = lfsr_q[31:0] ^ casr_q[31:0];

`else

    assign number_o = lfsr_q[31:0];

`endif

endmodule

// File: tb/tb_rng.sv
// Self-checking bench for rng: directed vectors plus a randomized run
// against a bit-level reference model of the LFSR and CASR rules.
module tb_rng;

    logic        clk = 1'b0;
    logic        reset;
    logic        loadseed_i;
    logic        enable;
    logic [31:0] seed_i;
    logic [31:0] number_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [42:0] m_l;
    logic [36:0] m_c;
    logic [31:0] rec [100];

`ifdef RNG_CASR_EN
    localparam bit CASR = 1'b1;
`else
    localparam bit CASR = 1'b0;
`endif

    localparam logic [31:0] RST_OUT  = CASR ? 32'h00000003 : 32'h00000001;
    localparam logic [31:0] LOAD_OUT = CASR ? 32'h00000000 : 32'h12345678;
    localparam logic [31:0] STEP_OUT = CASR ? 32'h091A2B3D : 32'h2468ACF1;

    rng dut (
        .clk       (clk),
        .reset     (reset),
        .loadseed_i(loadseed_i),
        .seed_i    (seed_i),
        .number_o  (number_o),
        .enable    (enable)
    );

    always #5 clk = ~clk;

    function automatic bit cbit(logic [36:0] c, int i);
        if (i < 0 || i > 36) return 1'b0;
        return c[i];
    endfunction

    task automatic m_reset();
        m_l = 43'd1;
        m_c = 37'd2;
    endtask

    task automatic m_edge(bit ld, bit en, logic [31:0] s);
        logic [36:0] nc;
        bit fb;
        if (ld) begin
            if (s == 0) begin
                m_reset();
            end else begin
                m_l = {11'd0, s};
                m_c = {5'd0, s};
            end
        end else if (en) begin
            fb  = m_l[42] ^ m_l[41] ^ m_l[20] ^ m_l[1];
            m_l = (m_l << 1) | 43'(fb);
            for (int i = 0; i < 37; i++) begin
                nc[i] = cbit(m_c, i - 1) ^ cbit(m_c, i + 1);
                if (i == 27) nc[i] = nc[i] ^ m_c[27];
            end
            m_c = nc;
        end
    endtask

    function automatic logic [31:0] m_out();
        return m_l[31:0] ^ (CASR ? m_c[31:0] : 32'd0);
    endfunction

    task automatic cycle(bit ld, bit en, logic [31:0] s);
        loadseed_i = ld;
        enable     = en;
        seed_i     = s;
        @(posedge clk);
        m_edge(ld, en, s);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        loadseed_i = 1'b0;
        enable     = 1'b0;
        seed_i     = 32'd0;
        #3;
        reset = 1'b1;
        m_reset();
        #1;
        n_cmp++;
        if (number_o !== RST_OUT) begin
            n_err++;
            $display("FAIL reset_async got %h exp %h", number_o, RST_OUT);
        end
        enable     = 1'b1;
        loadseed_i = 1'b1;
        seed_i     = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (number_o !== RST_OUT) begin
            n_err++;
            $display("FAIL reset_hold got %h exp %h", number_o, RST_OUT);
        end
        loadseed_i = 1'b0;
        enable     = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic test_load_step();
        cycle(1'b1, 1'b0, 32'h12345678);
        n_cmp++;
        if (number_o !== LOAD_OUT) begin
            n_err++;
            $display("FAIL load got %h exp %h", number_o, LOAD_OUT);
        end
        cycle(1'b0, 1'b1, 32'h0);
        n_cmp++;
        if (number_o !== STEP_OUT) begin
            n_err++;
            $display("FAIL step1 got %h exp %h", number_o, STEP_OUT);
        end
        n_cmp++;
        if (number_o !== m_out()) begin
            n_err++;
            $display("FAIL step1_model got %h exp %h", number_o, m_out());
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 32'hFFFFFFFF);
            n_cmp++;
            if (number_o !== STEP_OUT) begin
                n_err++;
                $display("FAIL hold%0d got %h exp %h", k, number_o, STEP_OUT);
            end
        end
    endtask

    task automatic test_priority();
        cycle(1'b0, 1'b1, 32'h0);
        cycle(1'b1, 1'b1, 32'h12345678);
        n_cmp++;
        if (number_o !== LOAD_OUT) begin
            n_err++;
            $display("FAIL load_prio got %h exp %h", number_o, LOAD_OUT);
        end
    endtask

    task automatic test_zero_seed();
        repeat (3) cycle(1'b0, 1'b1, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (number_o !== RST_OUT) begin
            n_err++;
            $display("FAIL zero_seed got %h exp %h", number_o, RST_OUT);
        end
        for (int k = 0; k < 300; k++) begin
            cycle(1'b0, 1'b1, 32'h0);
            n_cmp++;
            if (number_o !== m_out()) begin
                n_err++;
                $display("FAIL zs_run%0d got %h exp %h", k, number_o, m_out());
            end
        end
    endtask

    task automatic test_random();
        bit          ld;
        bit          en;
        logic [31:0] s;
        for (int k = 0; k < 3000; k++) begin
            ld = ($urandom_range(15) == 0);
            en = $urandom_range(3) != 0;
            s  = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            cycle(ld, en, s);
            n_cmp++;
            if (number_o !== m_out()) begin
                n_err++;
                $display("FAIL rand%0d got %h exp %h", k, number_o, m_out());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        s = 32'hA5C3_0F17;
        cycle(1'b1, 1'b0, s);
        for (int k = 0; k < 100; k++) begin
            cycle(1'b0, 1'b1, 32'h0);
            rec[k] = number_o;
        end
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        n_cmp++;
        if (number_o !== RST_OUT) begin
            n_err++;
            $display("FAIL mid_reset got %h exp %h", number_o, RST_OUT);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b0, 1'b1, 32'h0);
        n_cmp++;
        if (number_o !== m_out()) begin
            n_err++;
            $display("FAIL post_reset got %h exp %h", number_o, m_out());
        end
        cycle(1'b1, 1'b0, s);
        for (int k = 0; k < 100; k++) begin
            cycle(1'b0, 1'b1, 32'h0);
            n_cmp++;
            if (number_o !== rec[k] || number_o !== m_out()) begin
                n_err++;
                $display("FAIL replay%0d got %h exp %h", k, number_o, m_out());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_load_step();
        test_priority();
        test_zero_seed();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
